// File: rtl/fakeram_dp_param_if.sv
// Bundle of both access ports and clear-engine status for fakeram_dp_param.
// Master drives the accesses; slave is the RAM model.
interface fakeram_dp_param_if #(
   parameter int BITS       = 16,
   parameter int ADDR_WIDTH = 13
);
   logic                  rw0_ce_in;
   logic                  rw0_we_in;
   logic [ADDR_WIDTH-1:0] rw0_addr_in;
   logic [BITS-1:0]       rw0_wd_in;
   logic [BITS-1:0]       rw0_wmask_in;
   logic [BITS-1:0]       rw0_rd_out;
   logic                  rw0_rd_valid;
   logic                  rw0_addr_err;
   logic                  rw1_ce_in;
   logic                  rw1_we_in;
   logic [ADDR_WIDTH-1:0] rw1_addr_in;
   logic [BITS-1:0]       rw1_wd_in;
   logic [BITS-1:0]       rw1_wmask_in;
   logic [BITS-1:0]       rw1_rd_out;
   logic                  rw1_rd_valid;
   logic                  rw1_addr_err;
   logic                  init_busy;

   modport master (
      output rw0_ce_in, rw0_we_in, rw0_addr_in, rw0_wd_in, rw0_wmask_in,
      output rw1_ce_in, rw1_we_in, rw1_addr_in, rw1_wd_in, rw1_wmask_in,
      input  rw0_rd_out, rw0_rd_valid, rw0_addr_err,
      input  rw1_rd_out, rw1_rd_valid, rw1_addr_err, init_busy
   );

   modport slave (
      input  rw0_ce_in, rw0_we_in, rw0_addr_in, rw0_wd_in, rw0_wmask_in,
      input  rw1_ce_in, rw1_we_in, rw1_addr_in, rw1_wd_in, rw1_wmask_in,
      output rw0_rd_out, rw0_rd_valid, rw0_addr_err,
      output rw1_rd_out, rw1_rd_valid, rw1_addr_err, init_busy
   );
endinterface

// File: rtl/fakeram_dp_param.sv
// Two-port masked-write RAM model; read data READ_LATENCY (1 or 2) cycles after ce.
// No backpressure: accesses are dropped while the post-reset clear engine runs.
module fakeram_dp_param #(
   parameter int BITS           = 16,
   parameter int WORD_DEPTH     = 8192,
   parameter int ADDR_WIDTH     = 13,
   parameter int READ_LATENCY   = 1,
   parameter int RDW_MODE       = 0,
   parameter int COLLIDE_MODE   = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst,
   fakeram_dp_param_if.slave bus
);
   localparam logic [0:0]            S_IDLE  = 1'b0;
   localparam logic [0:0]            S_CLEAR = 1'b1;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(WORD_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(WORD_DEPTH - 1);

   if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
      $fatal(1, "fakeram_dp_param: READ_LATENCY must be 1 or 2");
   end
   if ((longint'(1) << ADDR_WIDTH) < longint'(WORD_DEPTH)) begin : g_bad_depth
      $fatal(1, "fakeram_dp_param: ADDR_WIDTH too small for WORD_DEPTH");
   end

   // Sized to the full address space so any address indexes safely; words >= WORD_DEPTH are never written.
   logic [BITS-1:0]       r_mem [0:(1 << ADDR_WIDTH)-1];
   logic [0:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic                  w_busy;

   logic                  w_ce   [2];
   logic                  w_we   [2];
   logic [ADDR_WIDTH-1:0] w_addr [2];
   logic [BITS-1:0]       w_wd   [2];
   logic [BITS-1:0]       w_wm   [2];
   logic [BITS-1:0]       w_old  [2];
   logic [BITS-1:0]       w_new  [2];
   logic [BITS-1:0]       w_rdat [2];
   logic                  w_oob  [2];
   logic                  w_acc  [2];
   logic                  w_wr   [2];
   logic                  w_collide;

   logic [BITS-1:0]       r_d1 [2];
   logic [BITS-1:0]       r_d2 [2];
   logic                  r_v1 [2];
   logic                  r_v2 [2];
   logic                  r_e1 [2];
   logic                  r_e2 [2];

   assign w_busy = (r_state == S_CLEAR);

   always_comb begin
      w_ce[0]   = bus.rw0_ce_in;
      w_we[0]   = bus.rw0_we_in;
      w_addr[0] = bus.rw0_addr_in;
      w_wd[0]   = bus.rw0_wd_in;
      w_wm[0]   = bus.rw0_wmask_in;
      w_ce[1]   = bus.rw1_ce_in;
      w_we[1]   = bus.rw1_we_in;
      w_addr[1] = bus.rw1_addr_in;
      w_wd[1]   = bus.rw1_wd_in;
      w_wm[1]   = bus.rw1_wmask_in;
      for (int p = 0; p < 2; p++) begin
         w_oob[p]  = ({1'b0, w_addr[p]} >= DEPTH_W);
         w_acc[p]  = w_ce[p] && !w_busy && !rst;
         w_wr[p]   = w_acc[p] && w_we[p] && !w_oob[p];
         w_old[p]  = r_mem[w_addr[p]];
         w_new[p]  = (w_old[p] & ~w_wm[p]) | (w_wd[p] & w_wm[p]);
         w_rdat[p] = w_oob[p] ? '0 : ((w_we[p] && RDW_MODE == 1) ? w_new[p] : w_old[p]);
      end
      w_collide = w_wr[0] && w_wr[1] && (w_addr[0] == w_addr[1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
         r_cnt   <= '0;
      end else if (r_state == S_CLEAR) begin
         r_cnt <= r_cnt + ADDR_WIDTH'(1);
         if (r_cnt == LAST_A) r_state <= S_IDLE;
      end
   end

   // rw1 is committed first so that rw0 overrides it on a same-address double write.
   always_ff @(posedge clk) begin
      if (w_busy) r_mem[r_cnt] <= '0;
      if (w_wr[1]) r_mem[w_addr[1]] <= w_new[1];
      if (w_wr[0]) r_mem[w_addr[0]] <= (w_collide && COLLIDE_MODE == 1) ? 'x : w_new[0];
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (rst) begin
            r_d1[p] <= '0;
            r_d2[p] <= '0;
            r_v1[p] <= 1'b0;
            r_v2[p] <= 1'b0;
            r_e1[p] <= 1'b0;
            r_e2[p] <= 1'b0;
         end else begin
            r_v1[p] <= w_acc[p];
            r_e1[p] <= w_acc[p] && w_oob[p];
            if (w_acc[p]) r_d1[p] <= w_rdat[p];
            r_v2[p] <= r_v1[p];
            r_e2[p] <= r_e1[p];
            if (r_v1[p]) r_d2[p] <= r_d1[p];
         end
      end
   end

   assign bus.rw0_rd_out   = (READ_LATENCY == 2) ? r_d2[0] : r_d1[0];
   assign bus.rw0_rd_valid = (READ_LATENCY == 2) ? r_v2[0] : r_v1[0];
   assign bus.rw0_addr_err = (READ_LATENCY == 2) ? r_e2[0] : r_e1[0];
   assign bus.rw1_rd_out   = (READ_LATENCY == 2) ? r_d2[1] : r_d1[1];
   assign bus.rw1_rd_valid = (READ_LATENCY == 2) ? r_v2[1] : r_v1[1];
   assign bus.rw1_addr_err = (READ_LATENCY == 2) ? r_e2[1] : r_e1[1];
   assign bus.init_busy    = w_busy;
endmodule
